// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard and the pipeline registers that carry
// the same destination-tracking fields.
package hazard_scoreboard_pkg;

   localparam int REG_IDX_W = 4;

   typedef logic [REG_IDX_W-1:0] reg_idx_t;

   typedef struct packed {
      logic     valid;
      reg_idx_t dest;
      logic     load;
   } sb_slot_t;

   localparam sb_slot_t SB_BUBBLE = '0;

endpackage

// File: rtl/hazard_scoreboard_slot_match.sv
// Combinational compare of one scoreboard slot against decode's source operands.
module sb_slot_match
   import hazard_scoreboard_pkg::*;
(
   input  sb_slot_t slot,
   input  reg_idx_t src1,
   input  reg_idx_t src2,
   input  logic     two_src,
   output logic     m1,
   output logic     m2
);

   // src1 is always a live operand; src2 only counts when decode says so.
   assign m1 = slot.valid & (slot.dest == src1);
   assign m2 = two_src & slot.valid & (slot.dest == src2);

endmodule

// File: rtl/hazard_scoreboard.sv
// EXE/MEM write-tracking scoreboard that raises the decode stall and counts
// stalled cycles; WB is untracked because the register file writes mid-cycle.
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter bit          FWD_EN = 1'b0,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  reg_idx_t         src1,
   input  reg_idx_t         src2,
   input  logic             Two_src,
   input  logic             id_wb_en,
   input  logic             id_mem_r_en,
   input  reg_idx_t         id_dest,
   input  logic             flush,
   input  logic             freeze,
   output logic             hazard,
   output logic             exe_busy,
   output logic             mem_busy,
   output logic [CNT_W-1:0] stall_cnt
);

   sb_slot_t s0;
   sb_slot_t s1;
   sb_slot_t s0_next;
   logic     s0_m1, s0_m2;
   logic     s1_m1, s1_m2;

   sb_slot_match u_match_exe (
      .slot    (s0),
      .src1    (src1),
      .src2    (src2),
      .two_src (Two_src),
      .m1      (s0_m1),
      .m2      (s0_m2)
   );

   sb_slot_match u_match_mem (
      .slot    (s1),
      .src1    (src1),
      .src2    (src2),
      .two_src (Two_src),
      .m1      (s1_m1),
      .m2      (s1_m2)
   );

   // With forwarding only a load still in EXE cannot be bypassed in time.
   always_comb begin
      hazard = 1'b0;
      if (FWD_EN)
         hazard = s0.load & (s0_m1 | s0_m2);
      else
         hazard = s0_m1 | s0_m2 | s1_m1 | s1_m2;
   end

   always_comb begin
      s0_next = SB_BUBBLE;
      if (!(hazard || flush))
         s0_next = '{valid: id_wb_en, dest: id_dest, load: id_mem_r_en};
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s0        <= SB_BUBBLE;
         s1        <= SB_BUBBLE;
         stall_cnt <= '0;
      end else if (!freeze) begin
         s1 <= s0;
         s0 <= s0_next;
         if (hazard && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign exe_busy = s0.valid;
   assign mem_busy = s1.valid;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed table-driven bench for hazard_scoreboard: a no-forwarding and a
// forwarding instance plus a 2-bit-counter instance share one stimulus stream.
module tb_hazard_scoreboard;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] src1, src2, id_dest;
   logic       two_src, id_wb_en, id_mem_r_en, flush, freeze;

   logic        nf_hz, nf_eb, nf_mb;
   logic [15:0] nf_cnt;
   logic        fw_hz, fw_eb, fw_mb;
   logic [15:0] fw_cnt;
   logic        sat_hz, sat_eb, sat_mb;
   logic [1:0]  sat_cnt;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(16)) u_nf (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .flush(flush), .freeze(freeze), .hazard(nf_hz), .exe_busy(nf_eb),
      .mem_busy(nf_mb), .stall_cnt(nf_cnt)
   );

   hazard_scoreboard #(.FWD_EN(1'b1), .CNT_W(16)) u_fw (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .flush(flush), .freeze(freeze), .hazard(fw_hz), .exe_busy(fw_eb),
      .mem_busy(fw_mb), .stall_cnt(fw_cnt)
   );

   hazard_scoreboard #(.FWD_EN(1'b0), .CNT_W(2)) u_sat (
      .clk(clk), .rst(rst), .src1(src1), .src2(src2), .Two_src(two_src),
      .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest),
      .flush(flush), .freeze(freeze), .hazard(sat_hz), .exe_busy(sat_eb),
      .mem_busy(sat_mb), .stall_cnt(sat_cnt)
   );

   typedef struct {
      logic [3:0] src1, src2;
      logic       two_src, wb_en, mem_r_en;
      logic [3:0] dest;
      logic       flush, freeze, do_edge;
      logic       nf_hz, nf_eb, nf_mb;
      int         nf_cnt;
      logic       fw_hz, fw_eb, fw_mb;
      int         fw_cnt;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                               input logic wb, input logic ld, input logic [3:0] d,
                               input logic fl, input logic fr, input logic ed,
                               input logic nh, input logic ne, input logic nm, input int nc,
                               input logic fh, input logic fe, input logic fm, input int fc);
      vec_t v;
      v.src1 = s1; v.src2 = s2; v.two_src = ts; v.wb_en = wb; v.mem_r_en = ld;
      v.dest = d; v.flush = fl; v.freeze = fr; v.do_edge = ed;
      v.nf_hz = nh; v.nf_eb = ne; v.nf_mb = nm; v.nf_cnt = nc;
      v.fw_hz = fh; v.fw_eb = fe; v.fw_mb = fm; v.fw_cnt = fc;
      return v;
   endfunction

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] s1, input logic [3:0] s2, input logic ts,
                                input logic wb, input logic ld, input logic [3:0] d,
                                input logic fl, input logic fr);
      src1 = s1; src2 = s2; two_src = ts; id_wb_en = wb; id_mem_r_en = ld;
      id_dest = d; flush = fl; freeze = fr;
   endtask

   task automatic checkOutput(input string tag,
                              input logic nh, input logic ne, input logic nm, input int nc,
                              input logic fh, input logic fe, input logic fm, input int fc);
      int sc;
      sc = (nc > 3) ? 3 : nc;
      check({tag, " nf.hazard"},    int'(nf_hz),  int'(nh));
      check({tag, " nf.exe_busy"},  int'(nf_eb),  int'(ne));
      check({tag, " nf.mem_busy"},  int'(nf_mb),  int'(nm));
      check({tag, " nf.stall_cnt"}, int'(nf_cnt), nc);
      check({tag, " fw.hazard"},    int'(fw_hz),  int'(fh));
      check({tag, " fw.exe_busy"},  int'(fw_eb),  int'(fe));
      check({tag, " fw.mem_busy"},  int'(fw_mb),  int'(fm));
      check({tag, " fw.stall_cnt"}, int'(fw_cnt), fc);
      check({tag, " sat.stall_cnt"}, int'(sat_cnt), sc);
   endtask

   initial begin
      logic skip_wait;

      //            s1 s2 ts wb ld d  fl fr ed   nf: hz eb mb cnt   fw: hz eb mb cnt
      vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0,        0, 0, 0, 0);
      vecs[1]  = mk(0, 0, 0, 1, 0, 1, 0, 0, 1,   0, 0, 0, 0,        0, 0, 0, 0);
      vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0,        0, 1, 0, 0);
      vecs[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 1, 1,        0, 0, 1, 0);
      vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 2,        0, 0, 0, 0);
      vecs[5]  = mk(0, 0, 0, 1, 0, 3, 0, 0, 1,   0, 0, 0, 2,        0, 0, 0, 0);
      vecs[6]  = mk(5, 3, 0, 0, 0, 0, 0, 0, 0,   0, 1, 0, 2,        0, 1, 0, 0);
      vecs[7]  = mk(5, 3, 1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 2,        0, 1, 0, 0);
      vecs[8]  = mk(5, 3, 1, 0, 0, 0, 0, 0, 1,   1, 0, 1, 3,        0, 0, 1, 0);
      vecs[9]  = mk(0, 0, 0, 1, 1, 2, 0, 0, 1,   0, 0, 0, 4,        0, 0, 0, 0);
      vecs[10] = mk(0, 2, 1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 4,        1, 1, 0, 0);
      vecs[11] = mk(0, 2, 1, 0, 0, 0, 0, 0, 1,   1, 0, 1, 5,        0, 0, 1, 1);
      vecs[12] = mk(0, 0, 0, 1, 0, 2, 0, 0, 1,   0, 0, 0, 6,        0, 0, 0, 1);
      vecs[13] = mk(0, 2, 1, 0, 0, 0, 0, 0, 1,   1, 1, 0, 6,        0, 1, 0, 1);
      vecs[14] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 1, 7,        0, 0, 1, 1);
      vecs[15] = mk(0, 0, 0, 1, 0, 4, 1, 0, 1,   0, 0, 0, 7,        0, 0, 0, 1);
      vecs[16] = mk(4, 0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 7,        0, 0, 0, 1);

      rst = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("reset", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      skip_wait = 1'b0;
      foreach (vecs[i]) begin
         if (!skip_wait)
            @(negedge clk);
         else
            #1;
         applyStimulus(vecs[i].src1, vecs[i].src2, vecs[i].two_src, vecs[i].wb_en,
                       vecs[i].mem_r_en, vecs[i].dest, vecs[i].flush, vecs[i].freeze);
         #1;
         checkOutput($sformatf("vec%0d", i), vecs[i].nf_hz, vecs[i].nf_eb, vecs[i].nf_mb,
                     vecs[i].nf_cnt, vecs[i].fw_hz, vecs[i].fw_eb, vecs[i].fw_mb, vecs[i].fw_cnt);
         skip_wait = !vecs[i].do_edge;
      end

      // Writer to r6 drifts into MEM, then freeze holds it there for three edges.
      @(negedge clk);
      applyStimulus(0, 0, 0, 1, 0, 6, 0, 0);
      #1 checkOutput("frz_issue", 0, 0, 0, 7, 0, 0, 0, 1);
      @(negedge clk);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("frz_exe", 0, 1, 0, 7, 0, 1, 0, 1);
      @(negedge clk);
      applyStimulus(6, 0, 0, 0, 0, 0, 0, 1);
      #1 checkOutput("frz_hold0", 1, 0, 1, 7, 0, 0, 1, 1);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         #1 checkOutput($sformatf("frz_hold%0d", k), 1, 0, 1, 7, 0, 0, 1, 1);
      end
      freeze = 1'b0;
      #1 checkOutput("frz_release", 1, 0, 1, 7, 0, 0, 1, 1);
      @(negedge clk);
      #1 checkOutput("frz_cleared", 0, 0, 0, 8, 0, 0, 0, 1);

      // Reset lands mid-cycle while a stall is active and must act before the next edge.
      @(negedge clk);
      applyStimulus(0, 0, 0, 1, 0, 7, 0, 0);
      @(negedge clk);
      applyStimulus(7, 0, 0, 0, 0, 0, 0, 0);
      #1 checkOutput("rst_pre", 1, 1, 0, 8, 0, 1, 0, 1);
      #2 rst = 1'b1;
      #1 checkOutput("rst_async", 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      rst = 1'b0;
      #1 checkOutput("rst_after", 0, 0, 0, 0, 0, 0, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $finish;
   end

endmodule
